fm_phase_cordic: RTL

Pipelined vectoring-mode CORDIC that converts the 64-bit conjugate-product stream {imag, real} from the FM demodulator multiply stage into an instantaneous phase (frequency discriminator) sample. It sits directly downstream of the conjugate-multiply stage and upstream of the audio decimator. One result is produced per accepted input, and the throughput is one sample per clock when the consumer is not stalling.

---
 rtl/fm_phase_cordic.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fm_phase_cordic.sv
// fm_phase_cordic: pipelined vectoring CORDIC turning {imag, real} into a phase angle (+-32768 = +-pi).
// Define FM_PHASE_MAG_EN to place the final-stage magnitude x[33:18] on m00_axis_tdata[31:16].
module fm_phase_cordic #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int ITERATIONS             = 16
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready
);

  localparam int LAST = ITERATIONS - 1;

  function automatic logic [15:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = 16'd8192;
      1:       atan_lut = 16'd4836;
      2:       atan_lut = 16'd2555;
      3:       atan_lut = 16'd1297;
      4:       atan_lut = 16'd651;
      5:       atan_lut = 16'd326;
      6:       atan_lut = 16'd163;
      7:       atan_lut = 16'd81;
      8:       atan_lut = 16'd41;
      9:       atan_lut = 16'd20;
      10:      atan_lut = 16'd10;
      11:      atan_lut = 16'd5;
      12:      atan_lut = 16'd3;
      13:      atan_lut = 16'd1;
      14:      atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

  logic               adv;
  logic signed [33:0] re_ext, im_ext;
  logic signed [33:0] x_q [ITERATIONS];
  logic signed [33:0] x_d [ITERATIONS];
  logic signed [33:0] y_q [ITERATIONS];
  logic signed [33:0] y_d [ITERATIONS];
  logic [15:0]        z_q [ITERATIONS+1];
  logic [15:0]        z_d [ITERATIONS+1];
  logic               v_q [ITERATIONS+1];
  logic               v_d [ITERATIONS+1];
  logic               l_q [ITERATIONS+1];
  logic               l_d [ITERATIONS+1];
  logic [3:0]         tstrb_q, tstrb_d;
  logic               unused_ok;

  assign adv             = m00_axis_tready || !m00_axis_tvalid;
  assign s00_axis_tready = s00_axis_aresetn && adv;
  // Widen before negating so -2^31 survives the pre-rotation.
  assign re_ext = {{2{s00_axis_tdata[31]}}, s00_axis_tdata[31:0]};
  assign im_ext = {{2{s00_axis_tdata[63]}}, s00_axis_tdata[63:32]};

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    v_d = v_q;
    l_d = l_q;
    if (!re_ext[33]) begin
      x_d[0] = re_ext;
      y_d[0] = im_ext;
      z_d[0] = 16'h0000;
    end else if (!im_ext[33]) begin
      x_d[0] = im_ext;
      y_d[0] = -re_ext;
      z_d[0] = 16'h4000;
    end else begin
      x_d[0] = -im_ext;
      y_d[0] = re_ext;
      z_d[0] = 16'hC000;
    end
    v_d[0] = s00_axis_tvalid && s00_axis_tready;
    l_d[0] = s00_axis_tlast;
    for (int i = 0; i < LAST; i++) begin
      if (!y_q[i][33]) begin
        x_d[i+1] = x_q[i] + (y_q[i] >>> i);
        y_d[i+1] = y_q[i] - (x_q[i] >>> i);
      end else begin
        x_d[i+1] = x_q[i] - (y_q[i] >>> i);
        y_d[i+1] = y_q[i] + (x_q[i] >>> i);
      end
    end
    for (int i = 0; i < ITERATIONS; i++) begin
      z_d[i+1] = y_q[i][33] ? z_q[i] - atan_lut(i) : z_q[i] + atan_lut(i);
      v_d[i+1] = v_q[i];
      l_d[i+1] = l_q[i];
    end
    tstrb_d = (adv && v_d[ITERATIONS]) ? 4'hF : tstrb_q;
  end

`ifdef FM_PHASE_MAG_EN
  logic signed [33:0] mag_q, mag_d;

  always_comb begin
    mag_d = y_q[LAST][33] ? x_q[LAST] - (y_q[LAST] >>> LAST)
                          : x_q[LAST] + (y_q[LAST] >>> LAST);
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) mag_q <= '0;
    else if (adv)          mag_q <= mag_d;
  end

  assign m00_axis_tdata = {mag_q[33:18], z_q[ITERATIONS]};
  assign unused_ok      = ^{s00_axis_tstrb, mag_q[17:0]};
`else
  assign m00_axis_tdata = {{16{z_q[ITERATIONS][15]}}, z_q[ITERATIONS]};
  // Without the magnitude output the final x and all but the sign of y are dead.
  assign unused_ok      = ^{s00_axis_tstrb, x_q[LAST], y_q[LAST][32:0]};
`endif

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      x_q     <= '{default: '0};
      y_q     <= '{default: '0};
      z_q     <= '{default: '0};
      v_q     <= '{default: 1'b0};
      l_q     <= '{default: 1'b0};
      tstrb_q <= 4'h0;
    end else begin
      if (adv) begin
        x_q <= x_d;
        y_q <= y_d;
        z_q <= z_d;
        v_q <= v_d;
        l_q <= l_d;
      end
      tstrb_q <= tstrb_d;
    end
  end

  assign m00_axis_tvalid = v_q[ITERATIONS];
  assign m00_axis_tlast  = l_q[ITERATIONS];
  assign m00_axis_tstrb  = tstrb_q;

endmodule
